// File: rtl/banked_ram_pkg.sv
// Shared constants, clear-sequencer states and helpers for the banked block-RAM.
// Each bank is built from 512x8 primitives, so the row field is always 9 bits.
package banked_ram_pkg;

  localparam int ROWS_PER_BANK = 512;
  localparam int BANK_AW       = 9;

  typedef enum logic {CLEAR, READY} clr_state_t;

  function automatic int lanes(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/ram_bank_lane.sv
// One 512x8 byte lane of one bank: iCE40 primitive for hardware builds,
// behavioural array with a registered read for simulation.
module ram_bank_lane
  import banked_ram_pkg::*;
(
  input  logic               clk,
  input  logic               re,
  input  logic [BANK_AW-1:0] raddr,
  input  logic               we,
  input  logic [BANK_AW-1:0] waddr,
  input  logic [7:0]         wdata,
  output logic [7:0]         rdata
);

`ifdef ICE40_PRIMITIVES
  SB_RAM512x8 u_prim (
    .RDATA (rdata),
    .RADDR (raddr),
    .RCLK  (clk),
    .RCLKE (1'b1),
    .RE    (re),
    .WADDR (waddr),
    .WCLK  (clk),
    .WCLKE (1'b1),
    .WDATA (wdata),
    .WE    (we)
  );
`else
  logic [7:0] mem [ROWS_PER_BANK];
  logic [7:0] rdata_reg;

  // Output register only moves on RE, matching the primitive's hold behaviour.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_reg <= mem[raddr];
  end

  assign rdata = rdata_reg;
`endif

endmodule

// File: rtl/banked_ram.sv
// WIDTH x (NUM_BANKS*512) memory from 512x8 lanes with byte enables, a one-cycle
// registered read, write-first forwarding and an optional post-reset clear.
module banked_ram
  import banked_ram_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int NUM_BANKS      = 3,
  parameter int CLEAR_ON_RESET = 1,
  parameter int AW             = $clog2(NUM_BANKS * ROWS_PER_BANK)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               re,
  input  logic [AW-1:0]      raddr,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [WIDTH/8-1:0] wbe,
  output logic [WIDTH-1:0]   rdata,
  output logic               rvalid,
  output logic               rerr,
  output logic               werr,
  output logic               ready
);

  localparam int LANES = lanes(WIDTH);
  localparam int BW    = (AW > BANK_AW) ? AW - BANK_AW : 1;
  localparam logic [BW:0] NB = (BW + 1)'(NUM_BANKS);

  logic [BW-1:0]      rbank, wbank;
  logic [BANK_AW-1:0] rrow, wrow;
  logic               r_in_range, w_in_range;
  logic               rd_acc, wr_acc;
  logic               clear_we;
  logic [BANK_AW-1:0] clr_row;

  assign rrow = raddr[BANK_AW-1:0];
  assign wrow = waddr[BANK_AW-1:0];

  generate
    if (AW > BANK_AW) begin : g_bank_field
      assign rbank = raddr[AW-1:BANK_AW];
      assign wbank = waddr[AW-1:BANK_AW];
    end else begin : g_single_bank
      assign rbank = '0;
      assign wbank = '0;
    end
  endgenerate

  assign r_in_range = {1'b0, rbank} < NB;
  assign w_in_range = {1'b0, wbank} < NB;

  // Clear sequencer: sweeps one row per cycle across every bank and lane.
  generate
    if (CLEAR_ON_RESET != 0) begin : g_clear
      clr_state_t         state_reg, state_next;
      logic [BANK_AW-1:0] cnt_reg, cnt_next;

      always_ff @(posedge clk) begin
        if (reset) begin
          state_reg <= CLEAR;
          cnt_reg   <= '0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
        end
      end

      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (state_reg == CLEAR) begin
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == BANK_AW'(ROWS_PER_BANK - 1)) state_next = READY;
        end
      end

      assign ready    = (state_reg == READY) && !reset;
      assign clear_we = (state_reg == CLEAR) && !reset;
      assign clr_row  = cnt_reg;
    end else begin : g_no_clear
      assign ready    = !reset;
      assign clear_we = 1'b0;
      assign clr_row  = '0;
    end
  endgenerate

  assign rd_acc = re && ready;
  assign wr_acc = we && ready;

  logic [WIDTH-1:0] bank_rdata [NUM_BANKS];

  genvar gi, gl;
  generate
    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      logic bank_re, bank_we;
      assign bank_re = rd_acc && r_in_range && (rbank == BW'(gi));
      assign bank_we = wr_acc && w_in_range && (wbank == BW'(gi));

      for (gl = 0; gl < LANES; gl++) begin : g_lane
        ram_bank_lane u_lane (
          .clk   (clk),
          .re    (bank_re),
          .raddr (rrow),
          .we    (clear_we || (bank_we && wbe[gl])),
          .waddr (clear_we ? clr_row : wrow),
          .wdata (clear_we ? 8'h00 : wdata[8*gl +: 8]),
          .rdata (bank_rdata[gi][8*gl +: 8])
        );
      end
    end
  endgenerate

  logic [BW-1:0]    rbank_reg;
  logic             rvalid_reg, rerr_reg, werr_reg, rzero_reg;
  logic [LANES-1:0] fwd_mask_reg;
  logic [WIDTH-1:0] fwd_data_reg;
  logic [WIDTH-1:0] bank_out;

  // Bank select, zero flag and forward mask only move on an accepted read, so
  // rdata holds its last value while re is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid_reg   <= 1'b0;
      rerr_reg     <= 1'b0;
      werr_reg     <= 1'b0;
      rzero_reg    <= 1'b1;
      rbank_reg    <= '0;
      fwd_mask_reg <= '0;
      fwd_data_reg <= '0;
    end else begin
      rvalid_reg <= rd_acc;
      rerr_reg   <= rd_acc && !r_in_range;
      werr_reg   <= wr_acc && !w_in_range && (|wbe);
      if (rd_acc) begin
        rbank_reg    <= rbank;
        rzero_reg    <= !r_in_range;
        fwd_mask_reg <= (wr_acc && (waddr == raddr)) ? wbe : '0;
        fwd_data_reg <= wdata;
      end
    end
  end

  always_comb begin
    bank_out = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (rbank_reg == BW'(b)) bank_out = bank_rdata[b];
    end
  end

  generate
    for (gl = 0; gl < LANES; gl++) begin : g_out
      assign rdata[8*gl +: 8] = rzero_reg          ? 8'h00 :
                                fwd_mask_reg[gl]   ? fwd_data_reg[8*gl +: 8] :
                                                     bank_out[8*gl +: 8];
    end
  endgenerate

  assign rvalid = rvalid_reg;
  assign rerr   = rerr_reg;
  assign werr   = werr_reg;

endmodule

// File: tb/tb_banked_ram.sv
// Directed checks of banked_ram (32-bit, 3 banks, clear on reset) plus a random
// sweep of a single-bank 8-bit instance without clear against a reference array.
module tb_banked_ram;

  logic        clk = 1'b0;
  logic        reset;
  logic        re, we;
  logic [10:0] raddr, waddr;
  logic [31:0] wdata, rdata;
  logic [3:0]  wbe;
  logic        rvalid, rerr, werr, ready;

  logic        s_re, s_we;
  logic [8:0]  s_raddr, s_waddr;
  logic [7:0]  s_wdata, s_rdata;
  logic [0:0]  s_wbe;
  logic        s_rvalid, s_rerr, s_werr, s_ready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  banked_ram #(.WIDTH(32), .NUM_BANKS(3), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .reset(reset), .re(re), .raddr(raddr), .we(we), .waddr(waddr),
    .wdata(wdata), .wbe(wbe), .rdata(rdata), .rvalid(rvalid), .rerr(rerr),
    .werr(werr), .ready(ready)
  );

  banked_ram #(.WIDTH(8), .NUM_BANKS(1), .CLEAR_ON_RESET(0)) dut_small (
    .clk(clk), .reset(reset), .re(s_re), .raddr(s_raddr), .we(s_we), .waddr(s_waddr),
    .wdata(s_wdata), .wbe(s_wbe), .rdata(s_rdata), .rvalid(s_rvalid), .rerr(s_rerr),
    .werr(s_werr), .ready(s_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts ready-low cycles (bounded) and notes any response flag seen meanwhile.
  task automatic wait_clear(output int n, output logic flags);
    n = 0;
    flags = 1'b0;
    while (!ready && n < 1000) begin
      n++;
      tick();
      flags = flags | rvalid | rerr | werr;
    end
  endtask

  task automatic wr(input logic [10:0] a, input logic [31:0] d, input logic [3:0] be,
                    input logic exp_err);
    we = 1'b1; waddr = a; wdata = d; wbe = be;
    tick();
    we = 1'b0;
    $display("wr  addr=%h data=%h wbe=%b werr=%0b", a, d, be, werr);
    check("werr", werr, exp_err);
  endtask

  task automatic rd(input logic [10:0] a, input logic [31:0] exp, input logic exp_err);
    re = 1'b1; raddr = a;
    tick();
    re = 1'b0;
    $display("rd  addr=%h data=%h rvalid=%0b rerr=%0b", a, rdata, rvalid, rerr);
    check("rvalid", rvalid, 1);
    check("rerr", rerr, exp_err);
    check("rdata", rdata, exp);
  endtask

  logic [7:0] mdl [512];
  logic [7:0] s_exp;
  int         n;
  logic       flags;
  int         rand_err;

  initial begin
    reset = 1'b1; re = 0; we = 0; raddr = 0; waddr = 0; wdata = 0; wbe = 0;
    s_re = 0; s_we = 0; s_raddr = 0; s_waddr = 0; s_wdata = 0; s_wbe = 0;
    tick();
    check("reset_rvalid", rvalid, 0);
    check("reset_rerr", rerr, 0);
    check("reset_werr", werr, 0);
    check("reset_rdata", rdata, 0);
    check("reset_ready", ready, 0);
    check("small_ready_in_reset", s_ready, 0);
    reset = 1'b0;
    #1;
    check("small_ready", s_ready, 1);

    // Requests during clear must be ignored.
    re = 1; raddr = 11'h600; we = 1; waddr = 11'h7FF; wbe = 4'hF;
    wait_clear(n, flags);
    re = 0; we = 0;
    $display("clear done after %0d cycles", n);
    check("clear_cycles", n, 512);
    check("clear_flags", flags, 0);

    rd(11'h000, 32'h0, 0);
    rd(11'h5FF, 32'h0, 0);
    tick();
    check("rvalid_idle", rvalid, 0);

    // Byte enables and bank isolation.
    wr(11'h205, 32'h11223344, 4'b1111, 0);
    wr(11'h205, 32'hAABBCCDD, 4'b0101, 0);
    rd(11'h205, 32'h11BB33DD, 0);
    rd(11'h005, 32'h0, 0);
    rd(11'h405, 32'h0, 0);

    // Write-first forwarding, then hold with re low, then a plain re-read.
    wr(11'h010, 32'hDEADBEEF, 4'b1111, 0);
    re = 1; raddr = 11'h010; we = 1; waddr = 11'h010; wdata = 32'h00000055; wbe = 4'b0001;
    tick();
    re = 0; we = 0;
    $display("rw  addr=010 data=%h rvalid=%0b", rdata, rvalid);
    check("fwd_rdata", rdata, 32'hDEADBE55);
    check("fwd_rvalid", rvalid, 1);
    tick();
    check("hold_rdata", rdata, 32'hDEADBE55);
    check("hold_rvalid", rvalid, 0);
    rd(11'h010, 32'hDEADBE55, 0);

    // Different addresses in the same cycle proceed independently.
    re = 1; raddr = 11'h205; we = 1; waddr = 11'h206; wdata = 32'h01020304; wbe = 4'hF;
    tick();
    re = 0; we = 0;
    check("indep_rdata", rdata, 32'h11BB33DD);
    rd(11'h206, 32'h01020304, 0);

    // Out of range.
    wr(11'h1FF, 32'hA1A1A1A1, 4'hF, 0);
    wr(11'h3FF, 32'hB2B2B2B2, 4'hF, 0);
    wr(11'h5FF, 32'hC3C3C3C3, 4'hF, 0);
    rd(11'h600, 32'h0, 1);
    wr(11'h7FF, 32'hFFFFFFFF, 4'hF, 1);
    tick();
    check("werr_pulse", werr, 0);
    wr(11'h7FF, 32'hFFFFFFFF, 4'h0, 0);
    rd(11'h1FF, 32'hA1A1A1A1, 0);
    rd(11'h3FF, 32'hB2B2B2B2, 0);
    rd(11'h5FF, 32'hC3C3C3C3, 0);

    // Reset with a read in flight, then reset again at clear row 300.
    re = 1; raddr = 11'h100; reset = 1;
    tick();
    re = 0; reset = 0;
    check("rst_rvalid", rvalid, 0);
    check("rst_ready", ready, 0);
    repeat (300) tick();
    check("mid_clear_ready", ready, 0);
    reset = 1;
    tick();
    reset = 0;
    wait_clear(n, flags);
    $display("clear restart done after %0d cycles", n);
    check("restart_cycles", n, 512);
    rd(11'h205, 32'h0, 0);

    // Single-bank 8-bit instance: fill, then back-to-back random traffic.
    for (int a = 0; a < 512; a++) begin
      s_we = 1; s_wbe = 1; s_waddr = 9'(a); s_wdata = 8'($urandom);
      mdl[a] = s_wdata;
      tick();
    end
    s_we = 0;
    rand_err = errors;
    s_re = 1;
    for (int i = 0; i < 2000; i++) begin
      s_raddr = 9'($urandom_range(0, 511));
      s_we    = 1'($urandom_range(0, 1));
      s_waddr = ($urandom_range(0, 3) == 0) ? s_raddr : 9'($urandom_range(0, 511));
      s_wdata = 8'($urandom);
      s_wbe   = 1'($urandom_range(0, 1));
      s_exp   = (s_we && s_wbe[0] && s_waddr == s_raddr) ? s_wdata : mdl[s_raddr];
      if (s_we && s_wbe[0]) mdl[s_waddr] = s_wdata;
      tick();
      check("sweep_rvalid", s_rvalid, 1);
      check("sweep_rdata", s_rdata, s_exp);
      check("sweep_rerr", s_rerr, 0);
    end
    s_re = 0; s_we = 0;
    $display("sweep 2000 ops, new errors=%0d", errors - rand_err);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
